// File: rtl/param_mux.sv
// Registered N-to-1 word multiplexer with out-of-range select detection.
// One-cycle latency; data and error flag hold while no select is offered.
module param_mux #(
    parameter int depth = 16,
    parameter int bits  = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     mux_valid_i,
    input  logic [$clog2(depth):0]   mux_sel_i,
    input  logic [bits-1:0]          mux_data_i [depth-1:0],
    output logic [bits-1:0]          mux_data_o,
    output logic                     mux_valid_o,
    output logic                     mux_err_o
);

    localparam int sel_w = $clog2(depth) + 1;

    logic [bits-1:0] sel_word;
    logic            in_range;

    // Full-width unsigned compare: no wrap of out-of-range indices.
    assign in_range = (mux_sel_i < sel_w'(depth));

    always_comb begin
        sel_word = '0;
        for (int k = 0; k < depth; k++) begin
            if (mux_sel_i == sel_w'(k)) begin
                sel_word = mux_data_i[k];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            mux_data_o  <= '0;
            mux_valid_o <= 1'b0;
            mux_err_o   <= 1'b0;
        end else if (mux_valid_i) begin
            mux_data_o  <= sel_word;
            mux_valid_o <= 1'b1;
            mux_err_o   <= !in_range;
        end else begin
            mux_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_param_mux.sv
// Self-checking bench for param_mux: depth 16 and depth 12 instances,
// directed scenarios followed by random traffic against a reference model.
module tb_param_mux;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       v16, v12;
    logic [4:0] s16, s12;
    logic [7:0] d16 [15:0];
    logic [7:0] d12 [11:0];
    logic [7:0] o16_d, o12_d;
    logic       o16_v, o16_e, o12_v, o12_e;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] e16_d, e12_d;
    logic       e16_v, e16_e, e12_v, e12_e;

    always #5 clk = ~clk;

    param_mux #(.depth(16), .bits(8)) u_mux16 (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .mux_valid_i (v16),
        .mux_sel_i   (s16),
        .mux_data_i  (d16),
        .mux_data_o  (o16_d),
        .mux_valid_o (o16_v),
        .mux_err_o   (o16_e)
    );

    param_mux #(.depth(12), .bits(8)) u_mux12 (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .mux_valid_i (v12),
        .mux_sel_i   (s12),
        .mux_data_i  (d12),
        .mux_data_o  (o12_d),
        .mux_valid_o (o12_v),
        .mux_err_o   (o12_e)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h",
                     tag, cyc, got, exp);
        end
    endtask

    // Reference: what each output register must hold after the edge.
    task automatic model_edge();
        int sel;
        if (!rst_n) begin
            e16_d = 8'h00; e16_v = 1'b0; e16_e = 1'b0;
            e12_d = 8'h00; e12_v = 1'b0; e12_e = 1'b0;
        end else begin
            if (v16) begin
                sel   = int'(s16);
                e16_d = (sel < 16) ? d16[sel] : 8'h00;
                e16_e = (sel >= 16);
                e16_v = 1'b1;
            end else begin
                e16_v = 1'b0;
            end
            if (v12) begin
                sel   = int'(s12);
                e12_d = (sel < 12) ? d12[sel] : 8'h00;
                e12_e = (sel >= 12);
                e12_v = 1'b1;
            end else begin
                e12_v = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        cyc++;
        #1;
        check("d16_data",  32'(o16_d), 32'(e16_d));
        check("d16_valid", 32'(o16_v), 32'(e16_v));
        check("d16_err",   32'(o16_e), 32'(e16_e));
        check("d12_data",  32'(o12_d), 32'(e12_d));
        check("d12_valid", 32'(o12_v), 32'(e12_v));
        check("d12_err",   32'(o12_e), 32'(e12_e));
    endtask

    task automatic sel16(input int s);
        v16 = 1'b1;
        s16 = 5'(s);
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        v16 = 1'b1; s16 = 5'd5;
        v12 = 1'b1; s12 = 5'd5;
        for (int k = 0; k < 16; k++) d16[k] = 8'(k * 17);
        for (int k = 0; k < 12; k++) d12[k] = 8'(k * 17);

        // Reset held with a valid select pending
        step();
        step();
        check("rst_data_const", 32'(o16_d), 32'h0);
        check("rst_valid_const", 32'(o16_v), 32'h0);

        // Full sweep
        rst_n = 1'b1;
        v12 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            sel16(k);
            check("sweep_const", 32'(o16_d), 32'(k * 17));
        end

        // Out of range, then recovery
        sel16(16);
        check("oor16_err_const", 32'(o16_e), 32'h1);
        sel16(31);
        check("oor31_data_const", 32'(o16_d), 32'h0);
        sel16(3);
        check("recover_const", 32'(o16_d), 32'h33);

        // Hold while idle, with data and select disturbed
        sel16(10);
        v16 = 1'b0; s16 = 5'd2; d16[10] = 8'h5A;
        for (int k = 0; k < 3; k++) begin
            step();
            check("hold_const", 32'(o16_d), 32'hAA);
        end
        d16[10] = 8'hAA;

        // Reset mid-stream at sel 7
        for (int k = 0; k < 7; k++) sel16(k);
        rst_n = 1'b0;
        sel16(7);
        check("midrst_const", 32'(o16_v), 32'h0);
        rst_n = 1'b1;
        sel16(8);
        check("post_rst_const", 32'(o16_d), 32'h88);

        // Non-power-of-two depth
        v16 = 1'b0;
        v12 = 1'b1; s12 = 5'd11;
        step();
        check("d12_11_const", 32'(o12_d), 32'hBB);
        for (int s = 12; s < 32; s++) begin
            s12 = 5'(s);
            step();
            check("d12_oor_const", 32'(o12_e), 32'h1);
        end

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 99) >= 3);
            v16 = ($urandom_range(0, 9) < 7);
            v12 = ($urandom_range(0, 9) < 7);
            s16 = 5'($urandom_range(0, 31));
            s12 = 5'($urandom_range(0, 31));
            for (int k = 0; k < 16; k++) d16[k] = 8'($urandom);
            for (int k = 0; k < 12; k++) d12[k] = 8'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
